// File: rtl/cla_seq_pkg.sv
// Shared types and default parameters for the carry-lookahead adder operand sequencer.
package cla_seq_pkg;

    localparam int N_DEFAULT       = 16;
    localparam int TIMEOUT_DEFAULT = 64;
    localparam int CNT_W_DEFAULT   = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_A    = 2'd1,
        SEND_B    = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/cla_result_reg.sv
// Downstream result holding register: sum plus timeout flag behind a valid/ready handshake.
module cla_result_reg #(
    parameter int W = 17
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         capture_i,
    input  logic [W-1:0] sum_i,
    input  logic         timeout_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] sum_o,
    output logic         timeout_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] sum_q, sum_d;
    logic         timeout_q, timeout_d;

    // A capture on the same edge as a consume keeps valid high with the new data.
    always_comb begin
        valid_d   = valid_q;
        sum_d     = sum_q;
        timeout_d = timeout_q;
        if (capture_i) begin
            valid_d   = 1'b1;
            sum_d     = sum_i;
            timeout_d = timeout_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            sum_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            sum_q     <= sum_d;
            timeout_q <= timeout_d;
        end
    end

    assign valid_o   = valid_q;
    assign sum_o     = sum_q;
    assign timeout_o = timeout_q;

endmodule

// File: rtl/cla_operand_sequencer.sv
// Serialises operand pairs onto the adder's shared bus, waits for done (or times out)
// and hands the captured sum downstream.
module cla_operand_sequencer
    import cla_seq_pkg::*;
#(
    parameter int N              = N_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [N-1:0]     op_a_i,
    input  logic [N-1:0]     op_b_i,
    input  logic             op_cin_i,
    output logic             add_start_o,
    output logic [N-1:0]     add_data_o,
    output logic             add_cin_o,
    input  logic             add_done_i,
    input  logic [N:0]       add_result_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [N:0]       res_sum_o,
    output logic             res_timeout_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] txn_count_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e           state_q;
    logic             add_start_q;
    logic [N-1:0]     add_data_q;
    logic             add_cin_q;
    logic [N-1:0]     b_q;
    logic [TW-1:0]    tmo_cnt_q;
    logic [CNT_W-1:0] txn_q, txn_d;

    logic             res_valid;
    logic             op_ready;
    logic             capture;
    logic             capture_timeout;
    logic [N:0]       capture_sum;

    assign op_ready = (state_q == IDLE) && (!res_valid || res_ready_i);

    // add_done only matters in WAIT_DONE; a real done beats a coincident timeout.
    assign capture         = (state_q == WAIT_DONE) && (add_done_i || (tmo_cnt_q == TMO_LAST));
    assign capture_timeout = !add_done_i;
    assign capture_sum     = add_done_i ? add_result_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            add_start_q <= 1'b0;
            add_data_q  <= '0;
            add_cin_q   <= 1'b0;
            b_q         <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_valid_i && op_ready) begin
                        add_start_q <= 1'b1;
                        add_data_q  <= op_a_i;
                        add_cin_q   <= op_cin_i;
                        b_q         <= op_b_i;
                        state_q     <= SEND_A;
                    end
                end
                SEND_A: begin
                    add_start_q <= 1'b0;
                    add_data_q  <= b_q;
                    state_q     <= SEND_B;
                end
                SEND_B: begin
                    tmo_cnt_q <= '0;
                    state_q   <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (capture) begin
                        state_q <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        txn_d = txn_q;
        if (res_valid && res_ready_i) begin
            txn_d = txn_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            txn_q <= '0;
        end else begin
            txn_q <= txn_d;
        end
    end

    cla_result_reg #(
        .W (N + 1)
    ) u_result_reg (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .capture_i (capture),
        .sum_i     (capture_sum),
        .timeout_i (capture_timeout),
        .ready_i   (res_ready_i),
        .valid_o   (res_valid),
        .sum_o     (res_sum_o),
        .timeout_o (res_timeout_o)
    );

    assign op_ready_o  = op_ready;
    assign res_valid_o = res_valid;
    assign add_start_o = add_start_q;
    assign add_data_o  = add_data_q;
    assign add_cin_o   = add_cin_q;
    assign busy_o      = (state_q != IDLE);
    assign txn_count_o = txn_q;

endmodule

// File: tb/tb_cla_operand_sequencer.sv
// Scoreboard bench for cla_operand_sequencer with a behavioural adder (done 3 cycles after start).
module tb_cla_operand_sequencer;

    localparam int N  = 16;
    localparam int TO = 64;

    typedef struct packed {
        logic [N:0] sum;
        logic       timeout;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        opValid = 1'b0;
    logic        opReady;
    logic [N-1:0] opA = '0;
    logic [N-1:0] opB = '0;
    logic        opCin = 1'b0;
    logic        addStart;
    logic [N-1:0] addData;
    logic        addCin;
    logic        addDone;
    logic [N:0]  addResult;
    logic        resValid;
    logic        resReady = 1'b1;
    logic [N:0]  resSum;
    logic        resTimeout;
    logic        busy;
    logic [15:0] txnCount;

    logic        modelDone;
    logic        modelOff = 1'b0;
    logic        tbDone = 1'b0;
    logic [1:0]  modelStage;
    logic [N-1:0] mA, mB;
    logic        mCin;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign addDone = modelDone | tbDone;

    cla_operand_sequencer #(
        .N              (N),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (16)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .op_valid_i    (opValid),
        .op_ready_o    (opReady),
        .op_a_i        (opA),
        .op_b_i        (opB),
        .op_cin_i      (opCin),
        .add_start_o   (addStart),
        .add_data_o    (addData),
        .add_cin_o     (addCin),
        .add_done_i    (addDone),
        .add_result_i  (addResult),
        .res_valid_o   (resValid),
        .res_ready_i   (resReady),
        .res_sum_o     (resSum),
        .res_timeout_o (resTimeout),
        .busy_o        (busy),
        .txn_count_o   (txnCount)
    );

    // Behavioural adder: latch A on start, B the cycle after, raise done for one cycle next.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelStage <= 2'd0;
            modelDone  <= 1'b0;
            addResult  <= '0;
            mA         <= '0;
            mB         <= '0;
            mCin       <= 1'b0;
        end else begin
            modelDone <= 1'b0;
            if (addStart) begin
                mA         <= addData;
                mCin       <= addCin;
                modelStage <= 2'd1;
            end else if (modelStage == 2'd1) begin
                mB         <= addData;
                modelStage <= 2'd2;
            end else if (modelStage == 2'd2) begin
                modelStage <= 2'd0;
                if (!modelOff) begin
                    modelDone <= 1'b1;
                    addResult <= {1'b0, mA} + {1'b0, mB} + {{N{1'b0}}, mCin};
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: compares every result consumed downstream against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && resValid && resReady) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedResult: got sum=%h timeout=%b, required no result", resSum, resTimeout);
            end else begin
                e = expQ.pop_front();
                checkOutput("resSum", 32'(resSum), 32'(e.sum));
                checkOutput("resTimeout", 32'(resTimeout), 32'(e.timeout));
            end
        end
    end

    // Drives one pair until accepted; returns at posedge+1 of the SEND_A cycle.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                                 input logic [N:0] expSum, input logic expTo, input bit doPush);
        exp_t e;
        bit accepted;
        accepted = 1'b0;
        if (doPush) begin
            e.sum     = expSum;
            e.timeout = expTo;
            expQ.push_back(e);
        end
        opA     = a;
        opB     = b;
        opCin   = cin;
        opValid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (opReady) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
                break;
            end
        end
        opValid = 1'b0;
        checkOutput("opAccepted", 32'(accepted), 32'd1);
    endtask

    task automatic waitDrain(input logic [15:0] expTxn);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drainDone", 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("txnCount", 32'(txnCount), 32'(expTxn));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;

        #12;
        checkOutput("rstAddStart", 32'(addStart), 32'd0);
        checkOutput("rstAddData", 32'(addData), 32'd0);
        checkOutput("rstResValid", 32'(resValid), 32'd0);
        checkOutput("rstTxnCount", 32'(txnCount), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] test 1: AAAA + 1111 + 1");
        applyStimulus(16'hAAAA, 16'h1111, 1'b1, 17'h0BBBC, 1'b0, 1'b1);
        checkOutput("t1StartPulse", 32'(addStart), 32'd1);
        checkOutput("t1DataA", 32'(addData), 32'h0000AAAA);
        checkOutput("t1CinA", 32'(addCin), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("t1StartLow", 32'(addStart), 32'd0);
        checkOutput("t1DataB", 32'(addData), 32'h00001111);
        waitDrain(16'd1);

        $display("[TB] test 2: FFFF + 0001 + 0");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0, 1'b1);
        waitDrain(16'd2);

        $display("[TB] test 3: held result with second pair pending");
        resReady = 1'b0;
        applyStimulus(16'hFFF0, 16'h000F, 1'b0, 17'h0FFFF, 1'b0, 1'b1);
        n = 0;
        while (!resValid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t3ResValid", 32'(resValid), 32'd1);
        expQ.push_back('{sum: 17'h05556, timeout: 1'b0});
        opA     = 16'h1234;
        opB     = 16'h4321;
        opCin   = 1'b1;
        opValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t3OpReadyLow", 32'(opReady), 32'd0);
            checkOutput("t3SumStable", 32'(resSum), 32'h0000FFFF);
        end
        @(posedge clk);
        #1;
        resReady = 1'b1;
        @(negedge clk);
        checkOutput("t3SameCycleAccept", 32'(opReady), 32'd1);
        @(posedge clk);
        #1;
        opValid = 1'b0;
        checkOutput("t3SecondStart", 32'(addStart), 32'd1);
        waitDrain(16'd4);

        $display("[TB] test 4: adder never completes");
        modelOff = 1'b1;
        applyStimulus(16'h0005, 16'h0006, 1'b0, 17'h00000, 1'b1, 1'b1);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (resValid) break;
        end
        checkOutput("t4TimeoutLatency", 32'(n), 32'(TO + 2));
        checkOutput("t4TimeoutFlag", 32'(resTimeout), 32'd1);
        checkOutput("t4TimeoutSum", 32'(resSum), 32'd0);
        modelOff = 1'b0;
        applyStimulus(16'h0100, 16'h0200, 1'b0, 17'h00300, 1'b0, 1'b1);
        waitDrain(16'd6);

        $display("[TB] test 5: stray done pulses");
        tbDone = 1'b1;
        @(posedge clk);
        #1;
        tbDone = 1'b0;
        checkOutput("t5IdleNoValid", 32'(resValid), 32'd0);
        checkOutput("t5IdleNoBusy", 32'(busy), 32'd0);
        applyStimulus(16'h0001, 16'h0002, 1'b1, 17'h00004, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        tbDone = 1'b1;
        @(posedge clk);
        #1;
        tbDone = 1'b0;
        checkOutput("t5SendBNoValid", 32'(resValid), 32'd0);
        checkOutput("t5SendBStillBusy", 32'(busy), 32'd1);
        waitDrain(16'd7);

        $display("[TB] test 6: reset during WAIT_DONE");
        applyStimulus(16'h0F0F, 16'h00F0, 1'b1, 17'h00000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("t6InWait", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6RstBusy", 32'(busy), 32'd0);
        checkOutput("t6RstAddData", 32'(addData), 32'd0);
        checkOutput("t6RstAddCin", 32'(addCin), 32'd0);
        checkOutput("t6RstResValid", 32'(resValid), 32'd0);
        checkOutput("t6RstTxnCount", 32'(txnCount), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("t6NoResult", 32'(resValid), 32'd0);
        checkOutput("t6TxnZero", 32'(txnCount), 32'd0);
        checkOutput("t6QueueEmpty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
